// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the iterative round sequencer.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (254 = 2+4+...+128), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = a;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from the current one and its rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_i;

  // SubWord(RotWord(w3)) with rcon folded into the leading byte
  assign t  = {sbox(w3[23:16]) ^ rcon_i, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES-128 encryptor: one full round per clock, IDLE/RUN/DONE handshake FSM.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NR = AES_NR  // only 10 is supported
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] pt_i,
  output logic         ready_o,
  output logic [127:0] ct_o,
  output logic         valid_o,
  input  logic         ack_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic [3:0]   round_o
);

  localparam int NUM_COLS = 4;

  fsm_e       fsm_q, fsm_d;
  state_t     state_q, state_d, rk_q, rk_d, rk_next, round_out;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_cur;
  logic       last_round;

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] ro [16];

  assign last_round = (round_q == 4'(NR));
  assign rcon_cur   = rcon(round_q);

  aes_key_step u_key_step (
    .rk_i   (rk_q),
    .rcon_i (rcon_cur),
    .rk_o   (rk_next)
  );

  // Byte b sits at column b/4, row b%4; the round key used is this round's new key.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[4*c+r] = sbox(state_q[127-8*(4*c+r) -: 8]);
      // row r rotates left by r: column c receives the byte from column c+r
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      assign ro[4*c+r] = (last_round ? sr[4*c+r] : mc[4*c+r]) ^ rk_next[127-8*(4*c+r) -: 8];
    end
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  always_comb begin
    round_out = '0;
    for (int i = 0; i < 16; i++) round_out[127-8*i -: 8] = ro[i];
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = pt_i ^ key_i;
          rk_d    = key_i;
          round_d = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          fsm_d   = ST_IDLE;
          state_d = '0;
          rk_d    = '0;
          round_d = '0;
        end else begin
          rk_d    = rk_next;
          state_d = round_out;
          if (last_round) fsm_d = ST_DONE;
          else            round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        // abort and ack land in the same cleared IDLE state, so priority is moot
        if (abort_i || ack_i) begin
          fsm_d   = ST_IDLE;
          state_d = '0;
          rk_d    = '0;
          round_d = '0;
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        state_d = '0;
        rk_d    = '0;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
    end
  end

  assign ready_o = (fsm_q == ST_IDLE);
  assign busy_o  = (fsm_q == ST_RUN);
  assign valid_o = (fsm_q == ST_DONE);
  assign ct_o    = valid_o ? state_q : '0;
  assign round_o = round_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq: known-answer and random vectors against a byte-level AES model.
module tb_aes_round_seq;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i, ack_i, abort_i;
  logic [127:0] key_i, pt_i, ct_o;
  logic         ready_o, valid_o, busy_o;
  logic [3:0]   round_o;

  int checks   = 0;
  int failures = 0;

  aes_round_seq #(.NR(10)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .key_i   (key_i),
    .pt_i    (pt_i),
    .ready_o (ready_o),
    .ct_o    (ct_o),
    .valid_o (valid_o),
    .ack_i   (ack_i),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .round_o (round_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference model ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int unsigned p = 0;
    int unsigned aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
    end
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (32'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] c = 8'h63;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = s;
    end
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp[0] = sbt[w[4*i-3]] ^ rc;
        tmp[1] = sbt[w[4*i-2]];
        tmp[2] = sbt[w[4*i-1]];
        tmp[3] = sbt[w[4*i-4]];
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          s[4*c+k] = (r == 10) ? t[4*c+k] :
                     gm(t[4*c+k], 8'h02) ^ gm(t[4*c+(k+1)%4], 8'h03) ^ t[4*c+(k+2)%4] ^ t[4*c+(k+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic accept(input logic [127:0] k, input logic [127:0] p, input logic with_abort);
    key_i   = k;
    pt_i    = p;
    start_i = 1'b1;
    abort_i = with_abort;
    chkn("ready_before_accept", int'(ready_o), 1);
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    key_i   = {$urandom, $urandom, $urandom, $urandom};
    pt_i    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // n counts edges from the accept edge inclusive; valid is expected once n reaches 11
  task automatic wait_done(input string nm, input logic [127:0] exp, input logic pulse_start);
    int n = 1;
    while (!valid_o && n < 30) begin
      chkn({nm, "_busy"}, int'(busy_o), 1);
      chkn({nm, "_ready_run"}, int'(ready_o), 0);
      chkn({nm, "_round"}, int'(round_o), n);
      chk({nm, "_ct_run"}, ct_o, '0);
      if (pulse_start && (n % 3 == 0)) begin
        start_i = 1'b1;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        pt_i    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start_i = 1'b0;
      end
      step();
      n++;
    end
    start_i = 1'b0;
    chkn({nm, "_latency"}, n, 11);
    chk({nm, "_ct"}, ct_o, exp);
    chkn({nm, "_round_done"}, int'(round_o), 10);
    chkn({nm, "_busy_done"}, int'(busy_o), 0);
    chkn({nm, "_ready_done"}, int'(ready_o), 0);
  endtask

  // start is also driven in the ack cycle and must not be taken
  task automatic do_ack(input string nm);
    ack_i   = 1'b1;
    start_i = 1'b1;
    chkn({nm, "_valid_pre_ack"}, int'(valid_o), 1);
    step();
    ack_i   = 1'b0;
    start_i = 1'b0;
    chkn({nm, "_valid_post_ack"}, int'(valid_o), 0);
    chkn({nm, "_ready_post_ack"}, int'(ready_o), 1);
    chkn({nm, "_busy_post_ack"}, int'(busy_o), 0);
    chkn({nm, "_round_post_ack"}, int'(round_o), 0);
    chk({nm, "_ct_post_ack"}, ct_o, '0);
  endtask

  task automatic chk_idle_clear(input string nm);
    chkn({nm, "_ready"}, int'(ready_o), 1);
    chkn({nm, "_valid"}, int'(valid_o), 0);
    chkn({nm, "_busy"}, int'(busy_o), 0);
    chkn({nm, "_round"}, int'(round_o), 0);
    chk({nm, "_ct"}, ct_o, '0);
    chk({nm, "_state"}, dut.state_q, '0);
    chk({nm, "_rk"}, dut.rk_q, '0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] held;
    rst_i = 1'b1; start_i = 1'b0; ack_i = 1'b0; abort_i = 1'b0;
    key_i = '0; pt_i = '0;
    build_sbox();

    vt[0] = '{KB, PB, CB};
    vt[1] = '{KC, PC, CC};
    for (int i = 2; i < 8; i++) begin
      vt[i].key = {$urandom, $urandom, $urandom, $urandom};
      vt[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vt[i].ct  = ref_aes(vt[i].key, vt[i].pt);
    end

    #12;
    chk_idle_clear("reset");
    rst_i = 1'b0;

    // table-driven: known answers plus random vectors vs the model
    for (int i = 0; i < 8; i++) begin
      accept(vt[i].key, vt[i].pt, 1'b0);
      wait_done($sformatf("vec%0d", i), vt[i].ct, 1'b0);
      do_ack($sformatf("vec%0d", i));
    end

    // DONE hold with start pulses during RUN
    accept(KB, PB, 1'b0);
    wait_done("hold", CB, 1'b1);
    held = ct_o;
    for (int i = 0; i < 20; i++) begin
      step();
      chkn("hold_valid", int'(valid_o), 1);
      chk("hold_ct", ct_o, held);
    end
    do_ack("hold");

    // abort at round 5, then a clean App. B request
    accept(KB, PB, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chkn("abort_at_round", int'(round_o), 5);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_idle_clear("abort_run");
    accept(KB, PB, 1'b0);
    wait_done("post_abort", CB, 1'b0);
    do_ack("post_abort");

    // asynchronous reset between edges at round 3
    accept(KC, PC, 1'b0);
    step();
    step();
    chkn("rst_at_round", int'(round_o), 3);
    #3;
    rst_i = 1'b1;
    #1;
    chk_idle_clear("midrun_reset");
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    accept(KC, PC, 1'b0);
    wait_done("post_reset", CC, 1'b0);
    do_ack("post_reset");

    // abort with start in IDLE: start wins; then abort with ack in DONE
    accept(KB, PB, 1'b1);
    wait_done("abort_start", CB, 1'b0);
    abort_i = 1'b1;
    ack_i   = 1'b1;
    step();
    abort_i = 1'b0;
    ack_i   = 1'b0;
    chk_idle_clear("abort_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start_i  input  1  request valid; a transfer is accepted when start_i && ready_o.
REQ-005 SHALL have key_i  input  128  cipher key; byte 0 is [127:120].
REQ-006 SHALL have pt_i  input  128  plaintext, column-major state; byte 0 is [127:120].
REQ-007 SHALL have ready_o  output  1  high only in IDLE.
REQ-008 SHALL have ct_o  output  128  ciphertext, same byte order as pt_i.
REQ-009 SHALL have valid_o  output  1  ciphertext valid; high only in DONE.
REQ-010 SHALL have ack_i  input  1  consumer accepts the result when valid_o && ack_i.
REQ-011 SHALL have abort_i  input  1  synchronous cancel of the current operation.
REQ-012 SHALL have busy_o  output  1  high in RUN.
REQ-013 SHALL have round_o  output  4  current round counter value.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 On accept in IDLE, SHALL perform these actions at that edge:
- state <= pt_i ^ key_i
- rk <= key_i
- round <= 1
- go to RUN
key_i and pt_i are not sampled after that edge.
REQ-016 In RUN, SHALL perform these actions at each edge:
- rk <= key_step(rk, rcon[round])
- state <= round function on the new rk: SubBytes, ShiftRows, MixColumns (omitted when round==NR), AddRoundKey.
REQ-017 In RUN, SHALL go to DONE at the edge where round==NR; otherwise SHALL increment round.
REQ-018 SHALL assert valid_o exactly 11 cycles after the accept edge, i.e. 1 init edge plus NR round edges.
REQ-019 ShiftRows SHALL rotate row r left by r byte positions, where row r holds bytes r, r+4, r+8 and r+12.
REQ-020 In DONE, SHALL hold ct_o at the final state; ct_o SHALL be 0 in IDLE and RUN.
REQ-021 In DONE, valid_o && ack_i SHALL return the FSM to IDLE, with ready_o high in the next cycle; no back-to-back accept occurs in the ack cycle.
REQ-022 In DONE with ack_i low, SHALL hold valid_o and ct_o stable indefinitely.
REQ-023 SHALL ignore start_i outside IDLE.
REQ-024 abort_i in RUN or DONE SHALL return the FSM to IDLE at the next edge and clear state, rk and round to 0.
REQ-025 If abort_i and ack_i are both high in DONE, abort SHALL take priority; the resulting state equals the REQ-024 result.
REQ-026 abort_i in IDLE SHALL have no effect; if abort_i and start_i are both high in IDLE, the start SHALL be accepted.
REQ-027 round_o SHALL be 0 in IDLE, 1..NR in RUN, and hold NR in DONE.
REQ-028 All arithmetic SHALL be GF(2^8) with polynomial 0x11B; the round counter is 4 bits and never wraps.

Reset
REQ-029 While rst_i is high, SHALL force IDLE, clear state, rk and round to 0, and drive ready_o=1, valid_o=0, busy_o=0, ct_o=0, round_o=0.
REQ-030 rst_i asserted mid-RUN or in DONE SHALL discard the operation immediately without waiting for a clock edge.
REQ-031 After rst_i deasserts, the first accept SHALL be possible at the first clock edge.

Structure
REQ-032 Package aes_pkg SHALL hold:
- the state_t typedef (128 bits)
- the FSM enum
- the NR constant
- the S-box function
- the xtime function
- the rcon table (1..10: 01 02 04 08 10 20 40 80 1B 36)
REQ-033 Sub-module aes_key_step SHALL compute the next AES-128 round key combinationally from rk and rcon.
REQ-034 The round function SHALL be combinational and the only registers SHALL be state, rk, round and FSM state; one round per cycle, with no multicycle paths.

Verification
REQ-035 Test FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, with valid_o high exactly 11 cycles after accept.
REQ-036 Test FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 Test DONE hold: hold ack_i low for 20 cycles, then pulse it -> ct_o stable throughout, valid_o drops and ready_o rises next cycle; start_i pulses during RUN are ignored.
REQ-038 Test abort: assert abort_i at round 5 -> IDLE and round_o=0 next cycle; a following App. B request -> correct ct.
REQ-039 Test mid-RUN reset: assert rst_i asynchronously between edges at round 3 -> outputs at reset values immediately; a post-reset App. C.1 request -> correct ct.
REQ-040 Test simultaneous events: abort_i with ack_i in DONE -> IDLE with state cleared; abort_i with start_i in IDLE -> request accepted and completed correctly.
